transpose_buffer_param: RTL and testbench

//  Parametrised, double-banked transpose buffer. Accepts ROWS row-beats of FETCH_W words per bank

---
 rtl/transpose_buffer_param_pkg.sv | 25 ++
 rtl/transpose_buffer_param_schedule.sv | 64 ++++++
 rtl/transpose_buffer_param.sv | 172 +++++++++++++++++
 tb/tb_transpose_buffer_param.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_buffer_param_pkg.sv
// Shared types for the double-banked transpose buffer: config width helper,
// the runtime loop-configuration record and the read-side state encoding.
package transpose_buffer_pkg;

  localparam int DEF_MAX_RANGE = 8;

  function automatic int calc_cfg_w(input int max_range);
    return $clog2(max_range) + 1;
  endfunction

  localparam int DEF_CFG_W = calc_cfg_w(DEF_MAX_RANGE);

  typedef struct packed {
    logic [DEF_CFG_W-1:0]                        range_inner;
    logic [DEF_CFG_W-1:0]                        range_outer;
    logic [DEF_CFG_W-1:0]                        stride;
    logic [DEF_MAX_RANGE-1:0][DEF_CFG_W-1:0]     indices;
  } tb_cfg_t;

  typedef enum logic {
    IDLE,
    RUN
  } rd_state_e;

endpackage

// File: rtl/transpose_buffer_param_schedule.sv
// Nested (outer, inner) loop counter producing the column to emit for each
// schedule step; inner runs fastest and both wrap to zero after the final step.
module tb_schedule_counter
  import transpose_buffer_pkg::*;
#(
  parameter int FETCH_W   = 4,
  parameter int MAX_RANGE = 8,
  parameter int CFG_W     = calc_cfg_w(MAX_RANGE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [CFG_W-1:0]                range_inner,
  input  logic [CFG_W-1:0]                range_outer,
  input  logic [CFG_W-1:0]                stride,
  input  logic [MAX_RANGE-1:0][CFG_W-1:0] indices,
  output logic [2*CFG_W-1:0]              col,
  output logic                            in_window,
  output logic                            last_step
);

  localparam int IDX_W = (MAX_RANGE > 1) ? $clog2(MAX_RANGE) : 1;
  localparam logic [CFG_W-1:0] MAX_CNT = CFG_W'(MAX_RANGE);

  logic [CFG_W-1:0] inner;
  logic [CFG_W-1:0] outer;
  logic [CFG_W-1:0] eff_inner;
  logic [CFG_W-1:0] eff_outer;
  logic             last_inner;
  logic             last_outer;

  // A zero count still runs one iteration; counts above the table size are clamped.
  function automatic logic [CFG_W-1:0] clamp_range(input logic [CFG_W-1:0] r);
    if (r == '0) return CFG_W'(1);
    if (r > MAX_CNT) return MAX_CNT;
    return r;
  endfunction

  always_comb begin
    eff_inner  = clamp_range(range_inner);
    eff_outer  = clamp_range(range_outer);
    last_inner = (inner == eff_inner - CFG_W'(1));
    last_outer = (outer == eff_outer - CFG_W'(1));
    last_step  = last_inner && last_outer;
    col        = {{CFG_W{1'b0}}, outer} * {{CFG_W{1'b0}}, stride}
               + {{CFG_W{1'b0}}, indices[inner[IDX_W-1:0]]};
    in_window  = (col < (2*CFG_W)'(FETCH_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inner <= '0;
      outer <= '0;
    end else if (en) begin
      if (last_inner) begin
        inner <= '0;
        outer <= last_outer ? '0 : outer + CFG_W'(1);
      end else begin
        inner <= inner + CFG_W'(1);
      end
    end
  end

endmodule

// File: rtl/transpose_buffer_param.sv
// Double-banked transpose buffer: rows arrive per bank over valid/ready, columns
// leave over valid/ready in an order set by a runtime nested-loop schedule.
module transpose_buffer_param
  import transpose_buffer_pkg::*;
#(
  parameter int  WORD_W    = 16,
  parameter int  FETCH_W   = 4,
  parameter int  ROWS      = 3,
  parameter int  MAX_RANGE = 8,
  localparam int CFG_W     = calc_cfg_w(MAX_RANGE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CFG_W-1:0]             cfg_range_inner,
  input  logic [CFG_W-1:0]             cfg_range_outer,
  input  logic [CFG_W-1:0]             cfg_stride,
  input  logic [MAX_RANGE*CFG_W-1:0]   cfg_indices,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FETCH_W*WORD_W-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS*WORD_W-1:0]       out_col,
  output logic                         out_last
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = 2 * CFG_W;

  logic [1:0][ROWS-1:0][FETCH_W-1:0][WORD_W-1:0] mem;
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [ROW_W-1:0]  wr_row;
  logic              wr_accept;
  logic              wr_done;

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic              start;
  logic              step;
  logic              bank_done;

  logic [CFG_W-1:0]                inner_q;
  logic [CFG_W-1:0]                outer_q;
  logic [CFG_W-1:0]                stride_q;
  logic [MAX_RANGE-1:0][CFG_W-1:0] indices_q;

  logic [COL_W-1:0]                col;
  logic                            in_window;
  logic                            last_step;
  logic [ROWS-1:0][WORD_W-1:0]     column;

  // Only registered flags feed in_ready, so a bank being released can never be rewritten in the same cycle.
  assign in_ready  = ~full[wr_bank];
  assign wr_accept = in_valid & in_ready;
  assign wr_done   = wr_accept && (wr_row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_bank][wr_row] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_done) begin
          wr_row        <= '0;
          wr_bank       <= ~wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_row <= wr_row + ROW_W'(1);
        end
      end
      if (bank_done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // A step only advances when the output register can take a new column.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    step      = 1'b0;
    bank_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (full[rd_bank]) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (~out_valid | out_ready) begin
          step = 1'b1;
          if (last_step) begin
            bank_done = 1'b1;
            if (full[~rd_bank]) start   = 1'b1;
            else                state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inner_q   <= '0;
      outer_q   <= '0;
      stride_q  <= '0;
      indices_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        inner_q   <= cfg_range_inner;
        outer_q   <= cfg_range_outer;
        stride_q  <= cfg_stride;
        indices_q <= cfg_indices;
      end
    end
  end

  tb_schedule_counter #(
    .FETCH_W   (FETCH_W),
    .MAX_RANGE (MAX_RANGE),
    .CFG_W     (CFG_W)
  ) u_schedule (
    .clk         (clk),
    .rst         (rst),
    .en          (step),
    .range_inner (inner_q),
    .range_outer (outer_q),
    .stride      (stride_q),
    .indices     (indices_q),
    .col         (col),
    .in_window   (in_window),
    .last_step   (last_step)
  );

  always_comb begin
    column = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < FETCH_W; c++) begin
        if (col == COL_W'(c)) column[r] = mem[rd_bank][r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_col   <= '0;
    end else if (step && in_window) begin
      out_valid <= 1'b1;
      out_last  <= last_step;
      out_col   <= column;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_buffer_param.sv
// Scoreboard bench for transpose_buffer_param: expected columns are queued when
// a bank is written and checked as the DUT hands columns over.
module tb_transpose_buffer_param;
  import transpose_buffer_pkg::*;

  localparam int WORD_W    = 16;
  localparam int FETCH_W   = 4;
  localparam int ROWS      = 3;
  localparam int MAX_RANGE = 8;
  localparam int CFG_W     = calc_cfg_w(MAX_RANGE);

  typedef struct {
    logic [ROWS*WORD_W-1:0] col;
    logic                   last;
  } exp_t;

  logic                        clk;
  logic                        rst;
  logic [CFG_W-1:0]            cfg_range_inner;
  logic [CFG_W-1:0]            cfg_range_outer;
  logic [CFG_W-1:0]            cfg_stride;
  logic [MAX_RANGE*CFG_W-1:0]  cfg_indices;
  logic                        in_valid;
  logic                        in_ready;
  logic [FETCH_W*WORD_W-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [ROWS*WORD_W-1:0]      out_col;
  logic                        out_last;

  exp_t                        exp_q[$];
  int                          assert_count = 0;
  int                          fail_count   = 0;
  int                          pop_count    = 0;
  logic                        stalled      = 1'b0;
  logic [ROWS*WORD_W-1:0]      held_col;
  logic                        held_last;

  transpose_buffer_param #(
    .WORD_W    (WORD_W),
    .FETCH_W   (FETCH_W),
    .ROWS      (ROWS),
    .MAX_RANGE (MAX_RANGE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_range_inner (cfg_range_inner),
    .cfg_range_outer (cfg_range_outer),
    .cfg_stride      (cfg_stride),
    .cfg_indices     (cfg_indices),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_col         (out_col),
    .out_last        (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run exceeded time limit, got time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic tb_cfg_t make_cfg(input int inner, input int outer, input int stride,
                                       input int i0, input int i1, input int i2, input int i3);
    tb_cfg_t c;
    c             = '0;
    c.range_inner = DEF_CFG_W'(inner);
    c.range_outer = DEF_CFG_W'(outer);
    c.stride      = DEF_CFG_W'(stride);
    c.indices[0]  = DEF_CFG_W'(i0);
    c.indices[1]  = DEF_CFG_W'(i1);
    c.indices[2]  = DEF_CFG_W'(i2);
    c.indices[3]  = DEF_CFG_W'(i3);
    return c;
  endfunction

  // Reference schedule: walks the loops independently and queues every in-window column.
  task automatic pushExpected(input tb_cfg_t c, input int base);
    int   ni;
    int   no;
    int   col;
    exp_t e;
    ni = (c.range_inner == 0) ? 1 : int'(c.range_inner);
    no = (c.range_outer == 0) ? 1 : int'(c.range_outer);
    if (ni > MAX_RANGE) ni = MAX_RANGE;
    if (no > MAX_RANGE) no = MAX_RANGE;
    for (int o = 0; o < no; o++) begin
      for (int i = 0; i < ni; i++) begin
        col = o * int'(c.stride) + int'(c.indices[i]);
        if (col < FETCH_W) begin
          for (int r = 0; r < ROWS; r++) e.col[r*WORD_W +: WORD_W] = WORD_W'(base + r*10 + col);
          e.last = (o == no - 1) && (i == ni - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Drives the config, queues the expected columns and sends one bank of rows.
  task automatic applyStimulus(input tb_cfg_t c, input int base);
    int n;
    cfg_range_inner = c.range_inner;
    cfg_range_outer = c.range_outer;
    cfg_stride      = c.stride;
    cfg_indices     = c.indices;
    pushExpected(c, base);
    for (int r = 0; r < ROWS; r++) begin
      in_valid = 1'b1;
      for (int k = 0; k < FETCH_W; k++) in_data[k*WORD_W +: WORD_W] = WORD_W'(base + r*10 + k);
      n = 0;
      while (!in_ready && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard pop plus hold-stability check while the consumer stalls.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_col",   64'(out_col),   64'(held_col));
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_last",  64'(out_last),  64'(held_last));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        pop_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_col", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("col",  64'(out_col),  64'(e.col));
          checkOutput("last", 64'(out_last), 64'(e.last));
        end
      end
      stalled   = out_valid && !out_ready;
      held_col  = out_col;
      held_last = out_last;
    end
  end

  task automatic runLatencyBank(input tb_cfg_t c, input int base, input string tag);
    applyStimulus(c, base);
    checkOutput({tag, "_lat0"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_lat2"}, 64'(out_valid), 64'd1);
    waitDrain({tag, "_drain"});
  endtask

  initial begin
    tb_cfg_t cfg1;
    tb_cfg_t cfg_s2;
    tb_cfg_t cfg_s3;
    logic    prev_ready;
    int      n;
    int      base_pop;

    cfg1   = make_cfg(4, 1, 0, 0, 1, 2, 3);
    cfg_s2 = make_cfg(2, 2, 2, 0, 1, 0, 0);
    cfg_s3 = make_cfg(2, 2, 3, 0, 1, 0, 0);

    rst             = 1'b1;
    in_valid        = 1'b0;
    in_data         = '0;
    out_ready       = 1'b1;
    cfg_range_inner = '0;
    cfg_range_outer = '0;
    cfg_stride      = '0;
    cfg_indices     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last",  64'(out_last),  64'd0);
    checkOutput("rst_out_col",   64'(out_col),   64'd0);
    @(posedge clk); #1;
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);

    $display("[TB] basic transpose");
    runLatencyBank(cfg1, 0, "t1");

    $display("[TB] stride windows");
    applyStimulus(cfg_s2, 100);
    waitDrain("t2a_drain");
    applyStimulus(cfg_s3, 200);
    waitDrain("t2b_drain");

    $display("[TB] both banks under backpressure");
    out_ready = 1'b0;
    applyStimulus(cfg1, 300);
    applyStimulus(cfg1, 400);
    checkOutput("t3_in_ready_full", 64'(in_ready), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_in_ready_held", 64'(in_ready), 64'd0);
    out_ready  = 1'b1;
    prev_ready = in_ready;
    n = 0;
    while (!(out_valid && out_last) && n < 100) begin
      prev_ready = in_ready;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t3_last_seen", 64'(out_valid && out_last), 64'd1);
    checkOutput("t3_ready_before_last", 64'(prev_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("t3_ready_after_last", 64'(in_ready), 64'd1);
    waitDrain("t3_drain");

    $display("[TB] toggling consumer");
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
      begin
        applyStimulus(cfg1, 500);
      end
    join
    out_ready = 1'b1;
    waitDrain("t4_drain");

    $display("[TB] reset mid-bank");
    base_pop = pop_count;
    applyStimulus(cfg1, 0);
    n = 0;
    while (pop_count < base_pop + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t5_two_popped", 64'(pop_count - base_pop), 64'd2);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    runLatencyBank(cfg1, 0, "t5");

    $display("[TB] config change mid-bank");
    out_ready = 1'b0;
    applyStimulus(cfg_s2, 600);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6_first_valid", 64'(out_valid), 64'd1);
    cfg_stride = DEF_CFG_W'(3);
    applyStimulus(cfg_s3, 700);
    out_ready = 1'b1;
    waitDrain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
